// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for dmem_arbiter: one instance per requesting port.
// master = requester, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;

    modport master (output req, we, lock, funct3, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, lock, funct3, addr, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with RISC-V funct3 decode and bus locking.
// Define DMEM_ARB_RR_EN for round-robin unlocked ties (default: port 0 wins).
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata
);
    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    logic [1:0]                 req, we, lock, gnt;
    logic [1:0][2:0]            f3;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][31:0]           wdata;

    assign req   = {p1.req,    p0.req};
    assign we    = {p1.we,     p0.we};
    assign lock  = {p1.lock,   p0.lock};
    assign f3    = {p1.funct3, p0.funct3};
    assign addr  = {p1.addr,   p0.addr};
    assign wdata = {p1.wdata,  p0.wdata};

    logic       own_vld, own_id, yield_vld, yield_id;
    logic       win_vld, win, tie_pick;
    logic [7:0] lock_cnt;

    // yield_vld: one-cycle window after a forced release where the other port goes first
    always_comb begin
        win_vld = 1'b0;
        win     = 1'b0;
        if (!reset) begin
            if (own_vld && req[own_id]) begin
                win_vld = 1'b1;
                win     = own_id;
            end else if (yield_vld && req[~yield_id]) begin
                win_vld = 1'b1;
                win     = ~yield_id;
            end else if (&req) begin
                win_vld = 1'b1;
                win     = tie_pick;
            end else if (|req) begin
                win_vld = 1'b1;
                win     = req[1];
            end
        end
    end

    assign gnt = {win_vld & win, win_vld & ~win};

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;
    assign tie_pick = rr_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (win_vld && !lock[win] && !(own_vld && own_id == win))
            rr_ptr <= ~win;
    end
`else
    assign tie_pick = 1'b0;
`endif

    logic                  w_we;
    logic [2:0]            w_f3;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            be;
    logic                  ill, acc_ok;

    assign w_we    = we[win];
    assign w_f3    = f3[win];
    assign w_addr  = addr[win];
    assign w_wdata = wdata[win];

    always_comb begin
        be  = 4'b0000;
        ill = 1'b0;
        case (w_f3)
            3'b000, 3'b100: be = 4'b0001 << w_addr[1:0];
            3'b001, 3'b101: begin
                be  = w_addr[1] ? 4'b1100 : 4'b0011;
                ill = w_addr[0];
            end
            3'b010: begin
                be  = 4'b1111;
                ill = |w_addr[1:0];
            end
            default: ill = 1'b1;
        endcase
        if (w_f3[2] && w_we) ill = 1'b1;
    end

    assign acc_ok   = win_vld & ~ill;
    assign mem_we   = acc_ok & w_we;
    assign mem_re   = acc_ok & ~w_we;
    assign mem_be   = acc_ok ? be : 4'b0000;
    assign mem_addr = win_vld ? {w_addr[ADDR_WIDTH-1:2], 2'b00} : '0;

    always_comb begin
        mem_wdata = 32'h0;
        if (win_vld) begin
            case (w_f3[1:0])
                2'b00:   mem_wdata = {4{w_wdata[7:0]}};
                2'b01:   mem_wdata = {2{w_wdata[15:0]}};
                default: mem_wdata = w_wdata;
            endcase
        end
    end

    logic [31:0] lane, ld_data;
    always_comb begin
        lane    = mem_rdata >> {w_addr[1:0], 3'b000};
        ld_data = 32'h0;
        if (mem_re) begin
            case (w_f3)
                3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
                3'b100:  ld_data = {24'h0, lane[7:0]};
                3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
                3'b101:  ld_data = {16'h0, lane[15:0]};
                default: ld_data = mem_rdata;
            endcase
        end
    end

    logic [1:0]       rvalid_q, err_q;
    logic [1:0][31:0] rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt & {2{ill}};
            for (int i = 0; i < 2; i++)
                rdata_q[i] <= gnt[i] ? ld_data : 32'h0;
        end
    end

    // Owner is granted whenever it requests, so in the owner branch a request means a grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_vld   <= 1'b0;
            own_id    <= 1'b0;
            lock_cnt  <= 8'd0;
            yield_vld <= 1'b0;
            yield_id  <= 1'b0;
        end else begin
            yield_vld <= 1'b0;
            if (own_vld) begin
                if (!req[own_id] || !lock[own_id]) begin
                    own_vld  <= 1'b0;
                    lock_cnt <= 8'd0;
                end else if (lock_cnt + 8'd1 == LOCK_LIM) begin
                    own_vld   <= 1'b0;
                    lock_cnt  <= 8'd0;
                    yield_vld <= 1'b1;
                    yield_id  <= own_id;
                end else begin
                    lock_cnt <= lock_cnt + 8'd1;
                end
            end else if (win_vld && lock[win]) begin
                if (LOCK_LIM == 8'd1) begin
                    yield_vld <= 1'b1;
                    yield_id  <= win;
                end else begin
                    own_vld  <= 1'b1;
                    own_id   <= win;
                    lock_cnt <= 8'd1;
                end
            end
        end
    end

    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata_q[0];
    assign p1.rdata  = rdata_q[1];
    assign p0.err    = err_q[0];
    assign p1.err    = err_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector tables, lock/reset
// sequences, and randomized traffic against a byte-level reference model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int LM = 4;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) p0_if ();
    dmem_arbiter_if #(.ADDR_WIDTH(AW)) p1_if ();

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic          mem_we, mem_re;

    dmem_arbiter #(.ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset), .p0(p0_if), .p1(p1_if),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata));

    // 256-byte memory behind the arbiter, cleared by reset
    logic [31:0] tmem [0:63];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) tmem[k] <= 32'h0;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) tmem[mem_addr[7:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end
    assign mem_rdata = tmem[mem_addr[7:2]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'h0, act}, {31'h0, exp});
    endtask

    task automatic drv(input int p, input logic rq, input logic w, input logic lk,
                       input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_if.req = rq; p0_if.we = w; p0_if.lock = lk;
            p0_if.funct3 = f; p0_if.addr = a; p0_if.wdata = d;
        end else begin
            p1_if.req = rq; p1_if.we = w; p1_if.lock = lk;
            p1_if.funct3 = f; p1_if.addr = a; p1_if.wdata = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata, wd_exp;
    } vec_t;

    typedef struct {
        logic r0, r1, l1, g0, g1;
    } lk_t;

    vec_t tv [23];
    lk_t  lt [9];

    // Reference model state for the random phase
    logic [7:0]  mm [0:255];
    logic        r_req [2], r_we [2], r_lk [2];
    logic [2:0]  r_f3 [2];
    logic [31:0] r_ad [2], r_wd [2];
    logic [2:0]  f3s [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    initial begin
        int own, cnt, yld, ptr, win, nb, prev_win, yld_n;
        logic legal, prev_err;
        logic [31:0] ev, exp_wd, prev_rd, mask;
        logic [3:0]  ebe;
        logic [7:0]  base;

        tv[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 3'b010, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0};
        tv[2]  = '{1'b0, 3'b000, 32'h13, 32'h0, 4'h8, 1'b0, 32'hFFFFFFDE, 32'h0};
        tv[3]  = '{1'b0, 3'b100, 32'h13, 32'h0, 4'h8, 1'b0, 32'h000000DE, 32'h0};
        tv[4]  = '{1'b0, 3'b001, 32'h12, 32'h0, 4'hC, 1'b0, 32'hFFFFDEAD, 32'h0};
        tv[5]  = '{1'b0, 3'b101, 32'h10, 32'h0, 4'h3, 1'b0, 32'h0000BEEF, 32'h0};
        tv[6]  = '{1'b1, 3'b000, 32'h11, 32'h55, 4'h2, 1'b0, 32'h0, 32'h55555555};
        tv[7]  = '{1'b0, 3'b010, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD55EF, 32'h0};
        tv[8]  = '{1'b1, 3'b001, 32'h12, 32'hABCD1234, 4'hC, 1'b0, 32'h0, 32'h12341234};
        tv[9]  = '{1'b0, 3'b010, 32'h10, 32'h0, 4'hF, 1'b0, 32'h123455EF, 32'h0};
        tv[10] = '{1'b0, 3'b000, 32'h11, 32'h0, 4'h2, 1'b0, 32'h00000055, 32'h0};
        tv[11] = '{1'b0, 3'b001, 32'h11, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[12] = '{1'b0, 3'b010, 32'h12, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[13] = '{1'b0, 3'b011, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[14] = '{1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[15] = '{1'b0, 3'b010, 32'h10, 32'h0, 4'hF, 1'b0, 32'h123455EF, 32'h0};
        tv[16] = '{1'b0, 3'b001, 32'h12, 32'h0, 4'hC, 1'b0, 32'h00001234, 32'h0};
        tv[17] = '{1'b0, 3'b110, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[18] = '{1'b1, 3'b111, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0};
        tv[19] = '{1'b0, 3'b000, 32'h12, 32'h0, 4'h4, 1'b0, 32'h00000034, 32'h0};
        tv[20] = '{1'b1, 3'b000, 32'h13, 32'h80, 4'h8, 1'b0, 32'h0, 32'h80808080};
        tv[21] = '{1'b0, 3'b000, 32'h13, 32'h0, 4'h8, 1'b0, 32'hFFFFFF80, 32'h0};
        tv[22] = '{1'b0, 3'b010, 32'hFFFFFF10, 32'h0, 4'hF, 1'b0, 32'h803455EF, 32'h0};

        // Port 1 locks with LOCK_MAX=4 while port 0 waits, then relocks and releases
        lt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        lt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        lt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state with both ports requesting
        reset = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h24, 32'h12345678);
        drv(1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h38, 32'h0);
        #12;
        chkb("rst gnt0", p0_if.gnt, 1'b0);
        chkb("rst gnt1", p1_if.gnt, 1'b0);
        chkb("rst rvalid0", p0_if.rvalid, 1'b0);
        chkb("rst rvalid1", p1_if.rvalid, 1'b0);
        chk("rst rdata0", p0_if.rdata, 32'h0);
        chkb("rst err0", p0_if.err, 1'b0);
        chkb("rst mem_we", mem_we, 1'b0);
        chkb("rst mem_re", mem_re, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst mem_be", {28'h0, mem_be}, 32'h0);
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Both ports requesting without lock
        drv(0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drv(1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h4, 32'h0);
        for (int k = 0; k < 6; k++) begin
            logic e0;
            e0 = RR ? (k % 2 == 0) : 1'b1;
            #1;
            chkb("tie gnt0", p0_if.gnt, e0);
            chkb("tie gnt1", p1_if.gnt, ~e0);
            tick();
            chkb("tie rvalid0", p0_if.rvalid, e0);
            chkb("tie rvalid1", p1_if.rvalid, ~e0);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();

        // Directed funct3 / alignment vectors on port 0
        for (int i = 0; i < 23; i++) begin
            drv(0, 1'b1, tv[i].we, 1'b0, tv[i].f3, tv[i].addr, tv[i].wdata);
            #1;
            chkb($sformatf("v%0d gnt0", i), p0_if.gnt, 1'b1);
            chkb($sformatf("v%0d mem_we", i), mem_we, tv[i].we & ~tv[i].err);
            chkb($sformatf("v%0d mem_re", i), mem_re, ~tv[i].we & ~tv[i].err);
            chk($sformatf("v%0d mem_addr", i), mem_addr, {tv[i].addr[31:2], 2'b00});
            if (!tv[i].err) chk($sformatf("v%0d mem_be", i), {28'h0, mem_be}, {28'h0, tv[i].be});
            if (!tv[i].err && tv[i].we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, tv[i].wd_exp);
            tick();
            chkb($sformatf("v%0d rvalid", i), p0_if.rvalid, 1'b1);
            chk($sformatf("v%0d rdata", i), p0_if.rdata, tv[i].rdata);
            chkb($sformatf("v%0d err", i), p0_if.err, tv[i].err);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();
        chkb("idle rvalid0", p0_if.rvalid, 1'b0);

        // Lock sequence
        for (int i = 0; i < 9; i++) begin
            drv(0, lt[i].r0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
            drv(1, lt[i].r1, 1'b0, lt[i].l1, 3'b010, 32'h8, 32'h0);
            #1;
            chkb($sformatf("lk%0d gnt0", i), p0_if.gnt, lt[i].g0);
            chkb($sformatf("lk%0d gnt1", i), p1_if.gnt, lt[i].g1);
            tick();
            chkb($sformatf("lk%0d rvalid1", i), p1_if.rvalid, lt[i].g1);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();

        // Reset the cycle after a load grant: the response must be dropped
        drv(0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        chkb("mid gnt0", p0_if.gnt, 1'b1);
        @(posedge clk);
        reset = 1'b1;
        #1;
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        chkb("mid rvalid0", p0_if.rvalid, 1'b0);
        chk("mid rdata0", p0_if.rdata, 32'h0);
        tick();
        chkb("mid rvalid0 hold", p0_if.rvalid, 1'b0);
        chkb("mid mem_re", mem_re, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        drv(0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        chkb("post gnt0", p0_if.gnt, 1'b1);
        chkb("post mem_re", mem_re, 1'b1);
        tick();
        chkb("post rvalid0", p0_if.rvalid, 1'b1);
        chkb("post err0", p0_if.err, 1'b0);
        drv(0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // Randomized traffic against the reference model, from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 256; k++) mm[k] = 8'h0;
        own = -1; cnt = 0; yld = -1; ptr = 0; prev_win = -1;
        prev_rd = 32'h0; prev_err = 1'b0;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_we[p] = 1'b0; r_lk[p] = 1'b0;
            r_f3[p] = 3'd0; r_ad[p] = 32'h0; r_wd[p] = 32'h0;
        end

        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] || cyc == 0) begin
                    r_req[p] = ($urandom_range(0, 9) < 6);
                    r_we[p]  = 1'($urandom_range(0, 1));
                    r_lk[p]  = ($urandom_range(0, 3) == 0);
                    r_f3[p]  = f3s[$urandom_range(0, 9)];
                    r_ad[p]  = 32'h40 + 32'($urandom_range(0, 191));
                    if ($urandom_range(0, 3) == 0) r_ad[p] = r_ad[p] | 32'hABC00000;
                    r_wd[p]  = $urandom;
                end
                drv(p, r_req[p], r_we[p], r_lk[p], r_f3[p], r_ad[p], r_wd[p]);
            end
            #1;

            if (own >= 0 && r_req[own]) win = own;
            else if (yld >= 0 && r_req[1-yld]) win = 1 - yld;
            else if (r_req[0] && r_req[1]) win = RR ? ptr : 0;
            else if (r_req[0]) win = 0;
            else if (r_req[1]) win = 1;
            else win = -1;

            chkb("rnd gnt0", p0_if.gnt, win == 0);
            chkb("rnd gnt1", p1_if.gnt, win == 1);

            if (win >= 0) begin
                case (r_f3[win])
                    3'd0, 3'd4: nb = 1;
                    3'd1, 3'd5: nb = 2;
                    3'd2:       nb = 4;
                    default:    nb = 0;
                endcase
                legal = (nb != 0) && !(r_f3[win][2] && r_we[win]) && (int'(r_ad[win][1:0]) % (nb == 0 ? 1 : nb) == 0);
                ebe = 4'((32'h1 << nb) - 1) << r_ad[win][1:0];
                for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = r_wd[win][8*(l % (nb == 0 ? 4 : nb)) +: 8];
                base = r_ad[win][7:0];
                ev = 32'h0;
                if (legal && !r_we[win]) begin
                    for (int b = 0; b < nb; b++) ev = ev | (32'(mm[8'(base + 8'(b))]) << (8*b));
                    if (nb < 4 && !r_f3[win][2]) begin
                        mask = (32'h1 << (8*nb)) - 32'h1;
                        if (ev[8*nb-1]) ev = ev | ~mask;
                    end
                end
                chkb("rnd mem_we", mem_we, legal && r_we[win]);
                chkb("rnd mem_re", mem_re, legal && !r_we[win]);
                chk("rnd mem_addr", mem_addr, {r_ad[win][31:2], 2'b00});
                if (legal) chk("rnd mem_be", {28'h0, mem_be}, {28'h0, ebe});
                if (legal && r_we[win]) begin
                    chk("rnd mem_wdata", mem_wdata, exp_wd);
                    for (int b = 0; b < nb; b++) mm[8'(base + 8'(b))] = r_wd[win][8*b +: 8];
                end
                prev_rd = ev;
                prev_err = !legal;
            end else begin
                chkb("rnd idle mem_we", mem_we, 1'b0);
                chkb("rnd idle mem_re", mem_re, 1'b0);
            end
            prev_win = win;

            // Arbitration state for the next cycle
            if (RR && win >= 0 && !r_lk[win] && own != win) ptr = 1 - win;
            yld_n = -1;
            if (own >= 0) begin
                if (!r_req[own] || !r_lk[own]) begin
                    own = -1; cnt = 0;
                end else begin
                    cnt++;
                    if (cnt == LM) begin yld_n = own; own = -1; cnt = 0; end
                end
            end else if (win >= 0 && r_lk[win]) begin
                own = win; cnt = 1;
                if (cnt == LM) begin yld_n = own; own = -1; cnt = 0; end
            end
            yld = yld_n;
            if (win >= 0) r_req[win] = 1'b0;

            tick();
            chkb("rnd rvalid0", p0_if.rvalid, prev_win == 0);
            chkb("rnd rvalid1", p1_if.rvalid, prev_win == 1);
            if (prev_win == 0) begin
                chk("rnd rdata0", p0_if.rdata, prev_rd);
                chkb("rnd err0", p0_if.err, prev_err);
            end else if (prev_win == 1) begin
                chk("rnd rdata1", p1_if.rdata, prev_rd);
                chkb("rnd err1", p1_if.err, prev_err);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
